regfile_issue_ctrl: RTL

//  Initiator side of the 32x32 register file. Decodes rs1[19:15]/rs2[24:20]/rd[11:7] from incoming

---
 rtl/regfile_issue_ctrl_pkg.sv | 24 ++
 rtl/regfile_issue_ctrl_decode.sv | 30 +++
 rtl/regfile_issue_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/regfile_issue_ctrl_pkg.sv
// Shared constants for the register-file issue controller: RV32 opcodes,
// instruction field positions and the issue FSM state encoding.
package regfile_issue_ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam int OPC_MSB = 6;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_ISSUE = 2'd2;

endpackage

// File: rtl/regfile_issue_ctrl_decode.sv
// Register-field decode: extracts rs1/rs2/rd and whether each is really used.
// x0 sources and an x0 destination are reported as unused.
module rv_reg_decode
   import regfile_issue_ctrl_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [24:0]   instr_i,
   output logic [AW-1:0] rs1_o,
   output logic [AW-1:0] rs2_o,
   output logic [AW-1:0] rd_o,
   output logic          uses_rs1_o,
   output logic          uses_rs2_o,
   output logic          has_rd_o
);

   logic [6:0] opc;

   assign opc = instr_i[OPC_MSB:0];

   always_comb begin
      rs1_o      = instr_i[RS1_LSB +: AW];
      rs2_o      = instr_i[RS2_LSB +: AW];
      rd_o       = instr_i[RD_LSB +: AW];
      uses_rs1_o = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL) && (rs1_o != '0);
      uses_rs2_o = (opc == OP_R || opc == OP_S || opc == OP_B) && (rs2_o != '0);
      has_rd_o   = !(opc == OP_S || opc == OP_B) && (rd_o != '0);
   end

endmodule

// File: rtl/regfile_issue_ctrl.sv
// Issue controller: holds one instruction, waits out RAW hazards on a busy-bit
// scoreboard, then presents a valid/ready operand bundle. Writeback is passed to the RF.
module regfile_issue_ctrl
   import regfile_issue_ctrl_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   output logic [AW-1:0]   rf_raddr1,
   output logic [AW-1:0]   rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   output logic            issue_valid,
   input  logic            issue_ready,
   output logic [31:0]     issue_instr,
   output logic [XLEN-1:0] issue_rs1_val,
   output logic [XLEN-1:0] issue_rs2_val,
   output logic [AW-1:0]   issue_rd,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [1:0]      dbg_state,
   output logic [NREG-1:0] dbg_busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // the sender holds valid and payload stable until that edge.

   logic [1:0]      state_q, state_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] rs1_val_q, rs1_val_d;
   logic [XLEN-1:0] rs2_val_q, rs2_val_d;
   logic [NREG-1:0] busy_q, busy_d;

   logic [AW-1:0]   rs1, rs2, rd;
   logic            uses_rs1, uses_rs2, has_rd;
   logic [NREG-1:0] clr_mask, set_mask, busy_eff;
   logic [XLEN-1:0] op1, op2;
   logic            hazard;

   rv_reg_decode #(.AW(AW)) u_decode (
      .instr_i    (instr_q[24:0]),
      .rs1_o      (rs1),
      .rs2_o      (rs2),
      .rd_o       (rd),
      .uses_rs1_o (uses_rs1),
      .uses_rs2_o (uses_rs2),
      .has_rd_o   (has_rd)
   );

   assign rf_raddr1     = rs1;
   assign rf_raddr2     = rs2;
   assign instr_ready   = (state_q == ST_IDLE) && !RESET;
   assign issue_valid   = (state_q == ST_ISSUE);
   assign issue_instr   = instr_q;
   assign issue_rs1_val = rs1_val_q;
   assign issue_rs2_val = rs2_val_q;
   assign issue_rd      = has_rd ? rd : '0;
   assign rf_we         = wb_valid && (wb_rd != '0);
   assign rf_waddr      = wb_rd;
   assign rf_wdata      = wb_data;
   assign dbg_state     = state_q;
   assign dbg_busy      = busy_q;

   // A writeback landing this cycle already resolves the hazard and supplies the operand.
   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (rf_we) clr_mask[wb_rd] = 1'b1;
      if (issue_valid && issue_ready && has_rd) set_mask[rd] = 1'b1;
      busy_eff = busy_q & ~clr_mask;
      busy_d   = busy_eff | set_mask;
      busy_d[0] = 1'b0;
      hazard = (uses_rs1 && busy_eff[rs1]) || (uses_rs2 && busy_eff[rs2]);
      op1 = '0;
      op2 = '0;
      if (uses_rs1) op1 = (rf_we && wb_rd == rs1) ? wb_data : rf_rdata1;
      if (uses_rs2) op2 = (rf_we && wb_rd == rs2) ? wb_data : rf_rdata2;
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      rs1_val_d = rs1_val_q;
      rs2_val_d = rs2_val_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               instr_d = instr;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!hazard) begin
               rs1_val_d = op1;
               rs2_val_d = op2;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issue_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         rs1_val_q <= '0;
         rs2_val_q <= '0;
         busy_q    <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         rs1_val_q <= rs1_val_d;
         rs2_val_q <= rs2_val_d;
         busy_q    <= busy_d;
      end
   end

endmodule
